vga_sequencer: RTL and testbench

VGA_SEQUENCER -- requirements
Module: vga_sequencer

---
 rtl/vga_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_vga_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_sequencer.sv
// vga_sequencer: VGA raster timing generator with a line-based 1bpp
// framebuffer fetch engine feeding a 2-entry pixel word buffer.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   fb_ack          framebuffer accepts the current request; fb_data valid same cycle
//   fb_data[31:0]   fetched pixel word, bit 0 = leftmost pixel
//   underrun_clr    clears the sticky underrun flag
//   fb_req          framebuffer read request
//   fb_addr[15:0]   word address (vcnt-Y_MIN)*WORDS_PER_LINE + word index
//   hcnt, vcnt      raster counters
//   hsync, vsync    active-low sync outputs
//   at_display      inside the visible window
//   pixel           current pixel value
//   frame_start     one-cycle pulse at hcnt=0, vcnt=0
//   underrun        sticky: a visible pixel was needed with the buffer empty
//
// Optional build: VGA_SEQUENCER_TESTPAT_EN adds input testpat; when high the
// block shows a checkerboard (hcnt[3]^vcnt[3]), issues no fetches and never
// flags underrun.
//
// All outputs are registered. Their next values are computed from the next
// counter and buffer state so they stay cycle-aligned with hcnt/vcnt.
module vga_sequencer #(
  parameter int H_TOTAL        = 208,
  parameter int V_TOTAL        = 666,
  parameter int HSYNC_END      = 24,
  parameter int VSYNC_END      = 6,
  parameter int X_MIN          = 37,
  parameter int X_MAX          = 197,
  parameter int Y_MIN          = 29,
  parameter int Y_MAX          = 629,
  parameter int WORDS_PER_LINE = 6
) (
  input  logic        clk,
  input  logic        rst,
`ifdef VGA_SEQUENCER_TESTPAT_EN
  input  logic        testpat,
`endif
  input  logic        fb_ack,
  input  logic [31:0] fb_data,
  input  logic        underrun_clr,
  output logic        fb_req,
  output logic [15:0] fb_addr,
  output logic [10:0] hcnt,
  output logic [10:0] vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        at_display,
  output logic        pixel,
  output logic        frame_start,
  output logic        underrun
);

  localparam int WW = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  logic tp;
`ifdef VGA_SEQUENCER_TESTPAT_EN
  assign tp = testpat;
`else
  assign tp = 1'b0;
`endif

  state_t         state_q, state_d;
  logic           run_q, run_d;
  logic [10:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d;
  logic           at_display_q, at_display_d;
  logic           frame_start_q, frame_start_d;
  logic           pixel_q, pixel_d;
  logic           underrun_q, underrun_d;
  logic           fb_req_q, fb_req_d;
  logic [15:0]    fb_addr_q, fb_addr_d;
  logic [WW-1:0]  widx_q, widx_d;
  logic [31:0]    ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]     cnt_q, cnt_d;

  logic           line_vis, line_end, pop, wr;
  logic [4:0]     bit_q, bit_d;

  always_comb begin
    // run_q holds the counters at 0/0 for the first edge after reset so that
    // the first live cycle already shows frame_start.
    run_d = 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!run_q) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == 11'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == 11'(V_TOTAL - 1)) ? '0 : vcnt_q + 11'd1;
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end

    hsync_d       = hcnt_d > 11'(HSYNC_END);
    vsync_d       = vcnt_d > 11'(VSYNC_END);
    at_display_d  = (hcnt_d >= 11'(X_MIN)) && (hcnt_d <= 11'(X_MAX)) &&
                    (vcnt_d >= 11'(Y_MIN)) && (vcnt_d <= 11'(Y_MAX));
    frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);

    // Buffer events for the current cycle.
    line_vis = (vcnt_q >= 11'(Y_MIN)) && (vcnt_q <= 11'(Y_MAX));
    line_end = hcnt_q == 11'(X_MAX + 1);
    bit_q    = 5'(hcnt_q - 11'(X_MIN));
    pop      = at_display_q && (cnt_q != 2'd0) &&
               ((bit_q == 5'd31) || (hcnt_q == 11'(X_MAX)));
    wr       = fb_req_q && fb_ack;

    // Fetch FSM; an unfinished line is abandoned at the end of the window.
    state_d = state_q;
    widx_d  = widx_q;
    case (state_q)
      IDLE:  if (hcnt_q == '0 && line_vis && !tp) begin
               state_d = REQ;
               widx_d  = '0;
             end
      REQ:   if (line_end) state_d = IDLE;
             else if (wr) begin
               widx_d = widx_q + 1'b1;
               if (widx_q == WW'(WORDS_PER_LINE - 1)) state_d = DRAIN;
             end
      DRAIN: if (line_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // 2-entry buffer, ent0 is the head.
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (line_end) cnt_d = '0;
    else begin
      case ({pop, wr})
        2'b10: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) ent0_d = fb_data;
          else               ent1_d = fb_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) ent0_d = fb_data;
          else begin
            ent0_d = ent1_q;
            ent1_d = fb_data;
          end
        end
        default: ;
      endcase
    end

    fb_req_d  = (state_d == REQ) && (cnt_d != 2'd2);
    fb_addr_d = fb_req_d ? 16'(16'(vcnt_q - 11'(Y_MIN)) * 16'(WORDS_PER_LINE) + 16'(widx_d))
                         : 16'd0;

    bit_d = 5'(hcnt_d - 11'(X_MIN));
    if (tp) pixel_d = at_display_d && (hcnt_d[3] ^ vcnt_d[3]);
    else    pixel_d = at_display_d && (cnt_d != 2'd0) && ent0_d[bit_d];

    underrun_d = (at_display_d && (cnt_d == 2'd0) && !tp) || (underrun_q && !underrun_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      at_display_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_q       <= 1'b0;
      underrun_q    <= 1'b0;
      fb_req_q      <= 1'b0;
      fb_addr_q     <= '0;
      widx_q        <= '0;
      ent0_q        <= '0;
      ent1_q        <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      at_display_q  <= at_display_d;
      frame_start_q <= frame_start_d;
      pixel_q       <= pixel_d;
      underrun_q    <= underrun_d;
      fb_req_q      <= fb_req_d;
      fb_addr_q     <= fb_addr_d;
      widx_q        <= widx_d;
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fb_req      = fb_req_q;
  assign fb_addr     = fb_addr_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign at_display  = at_display_q;
  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_sequencer.sv
// Randomized bench for vga_sequencer. The frame is shortened (V_TOTAL=44,
// Y_MAX=40) so several whole frames fit in a short run; line timing and
// the Y_MIN edge keep their default values.
module tb_vga_sequencer;
  localparam int H = 208, V = 44, YMIN = 29, YMAX = 40, XMIN = 37, XMAX = 197;
  localparam int WPL = 6, HSE = 24, VSE = 6;

  logic        clk, rst, fb_ack, underrun_clr, fb_req;
  logic [31:0] fb_data;
  logic [15:0] fb_addr;
  logic [10:0] hcnt, vcnt;
  logic        hsync, vsync, at_display, pixel, frame_start, underrun;
`ifdef VGA_SEQUENCER_TESTPAT_EN
  logic        testpat;
`endif

  vga_sequencer #(.V_TOTAL(V), .Y_MAX(YMAX)) u_dut (
    .clk(clk), .rst(rst),
`ifdef VGA_SEQUENCER_TESTPAT_EN
    .testpat(testpat),
`endif
    .fb_ack(fb_ack), .fb_data(fb_data), .underrun_clr(underrun_clr),
    .fb_req(fb_req), .fb_addr(fb_addr), .hcnt(hcnt), .vcnt(vcnt),
    .hsync(hsync), .vsync(vsync), .at_display(at_display), .pixel(pixel),
    .frame_start(frame_start), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: cycle number since reset release, a queue of fetched
  // words per line and a few flags.
  int          n, widx, mode, last_fs;
  logic [31:0] q[$];
  bit          act, done, ur, tp_m, forced;

  function automatic void model_reset();
    n = -1; widx = 0; act = 0; done = 0; ur = 0; q.delete(); last_fs = -1;
  endfunction

  function automatic void cur(output int h, output int v, output bit at);
    if (n < 0) begin h = 0; v = 0; at = 0; end
    else begin
      h = n % H; v = (n / H) % V;
      at = (h >= XMIN) && (h <= XMAX) && (v >= YMIN) && (v <= YMAX);
    end
  endfunction

  function automatic logic [63:0] outs();
    return 64'({hcnt, vcnt, hsync, vsync, at_display, pixel, frame_start, fb_req, fb_addr, underrun});
  endfunction

  task automatic check_cycle();
    int h, v, addr; bit at, req, pix, hs, vs, fs;
    cur(h, v, at);
    req  = act && !done && q.size() < 2;
    addr = req ? (v - YMIN) * WPL + widx : 0;
    hs   = n >= 0 && h > HSE;
    vs   = n >= 0 && v > VSE;
    fs   = n >= 0 && h == 0 && v == 0;
    if (tp_m) pix = at && (h[3] ^ v[3]);
    else      pix = at && q.size() > 0 && q[0][(h - XMIN) % 32];
    chk("outs", outs(), 64'({11'(h), 11'(v), hs, vs, at, pix, fs, req, 16'(addr), ur}));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 64'(n - last_fs), 64'(H * V));
      last_fs = n;
    end
  endtask

  task automatic drive();
    int h, v; bit at;
    cur(h, v, at);
    if (n >= 0 && h == 0) begin
      mode = $urandom_range(0, 3);
      if (forced && n / (H * V) == 0 && v == YMIN)     mode = 0;
      if (forced && n / (H * V) == 0 && v == YMIN + 1) mode = 1;
      if (forced && n / (H * V) == 0 && v == YMIN + 2) mode = 2;
      if (forced && n / (H * V) == 1 && v == 35)       mode = 1;
    end
    case (mode)
      0:       fb_ack = 1'b1;
      1:       fb_ack = 1'b0;
      2:       fb_ack = (n % 3 == 0);
      default: fb_ack = 1'($urandom_range(0, 1));
    endcase
    fb_data = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom();
    if (forced && n / (H * V) == 0 && v == YMIN) fb_data = 32'h1;
    underrun_clr = ($urandom_range(0, 63) == 0);
    if (forced && n / (H * V) == 0 && v == YMIN + 1 && (h == 100 || h == 205)) underrun_clr = 1'b1;
  endtask

  // Advance the model across one clock edge using the inputs just driven.
  task automatic step();
    int h, v; bit at, req, pop, wr;
    cur(h, v, at);
    if (n >= 0) begin
      req = act && !done && q.size() < 2;
      pop = at && q.size() > 0 && ((h - XMIN) % 32 == 31 || h == XMAX);
      wr  = req && fb_ack;
      if (pop) void'(q.pop_front());
      if (wr) begin
        q.push_back(fb_data);
        widx++;
        if (widx == WPL) done = 1;
      end
      if (h == XMAX + 1) begin act = 0; q.delete(); end
      if (h == 0 && v >= YMIN && v <= YMAX && !tp_m) begin act = 1; done = 0; widx = 0; end
    end
    n++;
    cur(h, v, at);
    ur = (at && q.size() == 0 && !tp_m) || (ur && !underrun_clr);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (n_fail > 20) break;
      check_cycle();
      drive();
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; fb_ack = 1'b0; fb_data = '0; underrun_clr = 1'b0;
    tp_m = 0; forced = 1; mode = 3;
`ifdef VGA_SEQUENCER_TESTPAT_EN
    testpat = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hold", outs(), 64'd0);
    rst = 1'b0;

    // Directed lines in frame 0, then into frame 1 up to (v=35, h=50)
    // where fb_ack is held low so a request is outstanding.
    run(H * V + 35 * H + 51);
    check_cycle();
    chk("req_before_rst", 64'(fb_req), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", outs(), 64'd0);
    @(negedge clk);
    chk("rst_hold2", outs(), 64'd0);
    rst = 1'b0; forced = 0;
    model_reset();
    run(2 * H * V + 10);

`ifdef VGA_SEQUENCER_TESTPAT_EN
    rst = 1'b1;
    @(negedge clk);
    testpat = 1'b1; tp_m = 1;
    rst = 1'b0;
    model_reset();
    run(H * V + 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
